ps2_scancode_decoder: RTL and testbench

Consumes the byte stream from the PS/2 receive stage, where each `dten` pulse carries one scancode byte on `kdata`. Interprets PS/2 set-2 framing: the `E0` extended prefix, the `F0` break prefix, the `E1` Pause sequence, fake-shift codes and controller status bytes. Emits one decoded key event per make or break into a small first-word-fall-through FIFO, which the keyboard-matrix / CPU-facing logic pops with `rd`.

---
 rtl/ps2_scancode_decoder.sv | 178 +++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0/E1 framing into make/break key events
// and queues them in a small first-word-fall-through FIFO for the CPU side.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dten,
    input  logic [7:0] kdata,
    input  logic       rd,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       overflow,
    output logic       seq_busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } event_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_pause_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;

    event_t        w_push_ev;
    logic          w_push_req;

    event_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    event_t        w_head;

    // Bytes that never start or complete a key event in IDLE.
    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == 8'hE0) || (b == 8'hF0);
    endfunction

    assign w_timeout = (r_state != ST_IDLE) && !dten && (r_to_cnt == TO_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_push_ev    = '{ext: 1'b0, brk: 1'b0, code: kdata};
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (dten) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (kdata == 8'hE0)      w_state_next = ST_E0;
                    else if (kdata == 8'hF0) w_state_next = ST_F0;
                    else if (kdata == 8'hE1) w_state_next = ST_PAUSE;
                    else if (!is_status(kdata)) w_push_req = 1'b1;
                end
                ST_E0: begin
                    if (kdata == 8'hF0)      w_state_next = ST_E0F0;
                    else if (kdata == 8'hE0) w_state_next = ST_E0;
                    else begin
                        w_state_next = ST_IDLE;
                        w_push_ev.ext = 1'b1;
                        w_push_req    = !is_fake_shift(kdata);
                    end
                end
                ST_F0: begin
                    w_state_next  = ST_IDLE;
                    w_push_ev.brk = 1'b1;
                    w_push_req    = !is_prefix(kdata);
                end
                ST_E0F0: begin
                    w_state_next  = ST_IDLE;
                    w_push_ev.ext = 1'b1;
                    w_push_ev.brk = 1'b1;
                    w_push_req    = !is_prefix(kdata) && !is_fake_shift(kdata);
                end
                ST_PAUSE: begin
                    if (r_pause_cnt == 3'd1) begin
                        w_state_next = ST_IDLE;
                        w_push_req   = 1'b1;
                        w_push_ev    = '{ext: 1'b1, brk: 1'b0, code: 8'h77};
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pause_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (dten && r_state == ST_IDLE && kdata == 8'hE1)
                r_pause_cnt <= 3'd7;
            else if (dten && r_state == ST_PAUSE)
                r_pause_cnt <= r_pause_cnt - 3'd1;
            if (dten || r_state == ST_IDLE || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = rd && !w_empty;
    // A pop frees the slot this same cycle, so a push into a full FIFO still lands.
    assign w_push  = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) r_overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the count gates visibility, so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_ev;
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign ev_valid = !w_empty;
    assign ev_code  = w_empty ? 8'h00 : w_head.code;
    assign ev_ext   = !w_empty && w_head.ext;
    assign ev_brk   = !w_empty && w_head.brk;
    assign overflow = r_overflow;
    assign seq_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: drives on the falling edge, samples
// just before driving, and compares against hand-computed events.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int TO    = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dten = 1'b0;
    logic [7:0] kdata = 8'h00;
    logic       rd = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       overflow;
    logic       seq_busy;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .dten     (dten),
        .kdata    (kdata),
        .rd       (rd),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_brk   (ev_brk),
        .overflow (overflow),
        .seq_busy (seq_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks enter and leave on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        dten  = 1'b1;
        kdata = b;
        @(negedge clk);
        dten  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code,
                                input logic ext, input logic brk);
        check({tag, ".valid"}, 32'(ev_valid), 32'd1);
        check({tag, ".code"},  32'(ev_code),  32'(code));
        check({tag, ".ext"},   32'(ev_ext),   32'(ext));
        check({tag, ".brk"},   32'(ev_brk),   32'(brk));
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        check({tag, ".valid"}, 32'(ev_valid), 32'd0);
        check({tag, ".code"},  32'(ev_code),  32'd0);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] fill [5];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        fill      = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};

        idle(2);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst.valid", 32'(ev_valid), 32'd0);
        check("rst.code",  32'(ev_code),  32'd0);
        check("rst.ext",   32'(ev_ext),   32'd0);
        check("rst.brk",   32'(ev_brk),   32'd0);
        check("rst.ovf",   32'(overflow), 32'd0);
        check("rst.busy",  32'(seq_busy), 32'd0);

        // Plain make, then break; event visible one cycle after the strobe
        send_byte(8'h1C);
        check("make.latency", 32'(ev_valid), 32'd1);
        send_byte(8'hF0);
        check("f0.busy", 32'(seq_busy), 32'd1);
        send_byte(8'h1C);
        expect_event("make1c", 8'h1C, 1'b0, 1'b0);
        expect_event("brk1c",  8'h1C, 1'b0, 1'b1);
        expect_empty("mb.drained");

        // Extended keys with fake shifts around them
        send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        expect_event("ext_make", 8'h75, 1'b1, 1'b0);
        expect_event("ext_brk",  8'h75, 1'b1, 1'b1);
        expect_empty("ext.drained");

        // Pause: eight bytes, one event after the last
        for (int i = 0; i < 7; i++) send_byte(pause_seq[i]);
        check("pause.busy7",  32'(seq_busy), 32'd1);
        check("pause.none7",  32'(ev_valid), 32'd0);
        send_byte(pause_seq[7]);
        check("pause.busy8",  32'(seq_busy), 32'd0);
        expect_event("pause", 8'h77, 1'b1, 1'b0);
        expect_empty("pause.drained");

        // Controller status bytes produce nothing
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'h00);
        check("status.none", 32'(ev_valid), 32'd0);
        check("status.busy", 32'(seq_busy), 32'd0);

        // Abandoned E0 prefix times out
        send_byte(8'hE0);
        idle(TO - 1);
        check("to.busy_before", 32'(seq_busy), 32'd1);
        idle(1);
        check("to.busy_after",  32'(seq_busy), 32'd0);
        send_byte(8'h1C);
        expect_event("to.after", 8'h1C, 1'b0, 1'b0);
        expect_empty("to.drained");

        // Pop requested on an empty FIFO in the push cycle is ignored
        rd = 1'b1;
        send_byte(8'h2B);
        rd = 1'b0;
        expect_event("empty_pushpop", 8'h2B, 1'b0, 1'b0);

        // Overflow: five makes into four slots
        for (int i = 0; i < 5; i++) send_byte(fill[i]);
        check("ovf.set", 32'(overflow), 32'd1);
        check("ovf.head", 32'(ev_code), 32'h1C);
        rd = 1'b1;
        send_byte(8'h33);
        rd = 1'b0;
        check("ovf.sticky", 32'(overflow), 32'd1);
        expect_event("full.e1", 8'h1B, 1'b0, 1'b0);
        expect_event("full.e2", 8'h23, 1'b0, 1'b0);
        expect_event("full.e3", 8'h2B, 1'b0, 1'b0);
        expect_event("full.e4", 8'h33, 1'b0, 1'b0);
        expect_empty("full.drained");
        check("ovf.still", 32'(overflow), 32'd1);

        // Asynchronous reset mid-sequence with queued events
        send_byte(8'h16); send_byte(8'h1E); send_byte(8'hE0);
        check("pre_rst.busy",  32'(seq_busy), 32'd1);
        check("pre_rst.valid", 32'(ev_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst.valid", 32'(ev_valid), 32'd0);
        check("async_rst.busy",  32'(seq_busy), 32'd0);
        check("async_rst.ovf",   32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h75);
        expect_event("post_rst", 8'h75, 1'b0, 1'b0);
        expect_empty("post_rst.drained");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
